// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its issue front end.
// The ALU imports alu_op_e from here, so the two always agree on encodings.
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SRA = 4'b0111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_e         ctrl;
        logic            is_branch;
        logic            ne;
    } issue_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / issue-out bundle of the ALU issue controller.
// master = the instruction source and ALU consumer side; slave = the issue controller.
interface alu_issue_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_a;
    logic [XLEN-1:0]  out_b;
    logic [3:0]       out_alu_ctrl;
    logic             out_is_branch;
    logic             out_branch_ne;
    logic             illegal_pulse;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_ctrl,
               out_is_branch, out_branch_ne, illegal_pulse, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_ctrl,
               out_is_branch, out_branch_ne, illegal_pulse, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_fifo.sv
// Two-entry issue queue with 1-bit wrapping pointers; head reads zero when empty.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter type T = issue_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output logic full_o,
    output logic valid_o,
    output T     rdata_o
);
    T           mem_q [2];
    logic       wptr_q, rptr_q;
    logic [1:0] cnt_q;
    logic       do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign rdata_o = valid_o ? mem_q[rptr_q] : T'('0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= T'('0);
            mem_q[1] <= T'('0);
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) rptr_q <= ~rptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// RV64 integer decode into ALU op + operand B, queued for the ALU under valid/ready.
// Unsupported encodings are consumed, never issued, and counted.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus
);
    logic [31:0]     instr;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, shamt;
    logic            legal, is_br, br_ne;
    alu_op_e         op;
    logic [XLEN-1:0] opb;
    logic            unused_rs1_field;

    assign instr = bus.in_instr;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = sext12(instr[31:20]);
    assign imm_s = sext12({instr[31:25], instr[11:7]});
    assign shamt = {{(XLEN-6){1'b0}}, instr[25:20]};
    // Register indices are resolved upstream; only the values arrive here.
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        legal = 1'b0;
        is_br = 1'b0;
        br_ne = 1'b0;
        op    = ALU_ADD;
        opb   = bus.in_rs2;
        if (instr[1:0] == 2'b11) begin
            case (opc)
                OPC_OP: begin
                    case (f3)
                        3'b000: begin
                            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                            op    = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        end
                        3'b101: begin
                            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                            op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        end
                        3'b001: begin legal = (f7 == F7_BASE); op = ALU_SLL; end
                        3'b100: begin legal = (f7 == F7_BASE); op = ALU_XOR; end
                        3'b110: begin legal = (f7 == F7_BASE); op = ALU_OR;  end
                        3'b111: begin legal = (f7 == F7_BASE); op = ALU_AND; end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_OP_IMM: begin
                    opb = imm_i;
                    case (f3)
                        3'b000: begin legal = 1'b1; op = ALU_ADD; end
                        3'b100: begin legal = 1'b1; op = ALU_XOR; end
                        3'b110: begin legal = 1'b1; op = ALU_OR;  end
                        3'b111: begin legal = 1'b1; op = ALU_AND; end
                        3'b001: begin
                            opb   = shamt;
                            legal = (instr[31:26] == 6'b000000);
                            op    = ALU_SLL;
                        end
                        3'b101: begin
                            opb   = shamt;
                            legal = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
                            op    = instr[30] ? ALU_SRA : ALU_SRL;
                        end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_LOAD:  begin legal = 1'b1; opb = imm_i; end
                OPC_STORE: begin legal = 1'b1; opb = imm_s; end
                OPC_BRANCH: begin
                    legal = (f3 == 3'b000) || (f3 == 3'b001);
                    op    = ALU_SUB;
                    is_br = 1'b1;
                    br_ne = f3[0];
                end
                default: legal = 1'b0;
            endcase
        end
    end

    logic   full, accept, push, pop;
    issue_t wdata, head;
    logic   ill_pulse_q;
    logic [CNT_W-1:0] ill_cnt_q;

    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;
    assign pop    = bus.out_valid && bus.out_ready;

    assign wdata = '{a: bus.in_rs1, b: opb, ctrl: op, is_branch: is_br, ne: br_ne};

    alu_issue_fifo #(.T(issue_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .full_o  (full),
        .valid_o (bus.out_valid),
        .rdata_o (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_pulse_q <= 1'b0;
            ill_cnt_q   <= '0;
        end else begin
            ill_pulse_q <= accept && !legal;
            if (accept && !legal && !(&ill_cnt_q)) ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready      = !full;
    assign bus.out_a         = head.a;
    assign bus.out_b         = head.b;
    assign bus.out_alu_ctrl  = head.ctrl;
    assign bus.out_is_branch = head.is_branch;
    assign bus.out_branch_ne = head.ne;
    assign bus.illegal_pulse = ill_pulse_q;
    assign bus.illegal_cnt   = ill_cnt_q;
endmodule
